// File: rtl/game_seq_pkg.sv
// Shared definitions for the game-flow sequencer: state encoding, timing
// defaults and a width helper.
package game_seq_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PLAY     = 3'd1;
  localparam logic [2:0] CRASH    = 3'd2;
  localparam logic [2:0] GRACE    = 3'd3;
  localparam logic [2:0] GAMEOVER = 3'd4;

  typedef enum logic [2:0] {
    StIdle     = IDLE,
    StPlay     = PLAY,
    StCrash    = CRASH,
    StGrace    = GRACE,
    StGameover = GAMEOVER
  } state_e;

  localparam int unsigned DEF_UPD_PERIOD  = 833333;
  localparam int unsigned DEF_FAST_PERIOD = 416667;
  localparam int unsigned DEF_CRASH_TICKS = 120;
  localparam int unsigned DEF_GRACE_TICKS = 90;
  localparam int unsigned DEF_BLINK_TICKS = 8;
  localparam int unsigned DEF_LIVES       = 3;

  // Bits needed to hold 0..v-1; never less than 1 so a counter always exists.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-PERIOD counter producing a tick on its last count;
// clear restarts the period from zero.
module tick_divider
  import game_seq_pkg::*;
#(
  parameter int unsigned PERIOD = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = clog2(PERIOD);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: attract / play / crash / grace / game-over sequencing,
// lives, update strobes and player blink mask.
module game_sequencer
  import game_seq_pkg::*;
#(
  parameter int unsigned UPD_PERIOD  = DEF_UPD_PERIOD,
  parameter int unsigned FAST_PERIOD = DEF_FAST_PERIOD,
  parameter int unsigned CRASH_TICKS = DEF_CRASH_TICKS,
  parameter int unsigned GRACE_TICKS = DEF_GRACE_TICKS,
  parameter int unsigned BLINK_TICKS = DEF_BLINK_TICKS,
  parameter int unsigned LIVES       = DEF_LIVES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       colision,
  output logic       upsig,
  output logic       upsig_fast,
  output logic       alive,
  output logic       player_visible,
  output logic       score_clear,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int unsigned TW = clog2(CRASH_TICKS > GRACE_TICKS ? CRASH_TICKS : GRACE_TICKS);
  localparam int unsigned BW = clog2(BLINK_TICKS);

  state_e          state_q, state_d;
  logic [1:0]      lives_q;
  logic            col_q, start_q, start_rise_q;
  logic [TW-1:0]   tick_cnt_q;
  logic [BW-1:0]   blink_cnt_q;
  logic            visible_q, upsig_q, upsig_fast_q, alive_q, game_over_q, score_clear_q;
  logic            slow_tick, fast_tick, transition, running, blinking, starting;

  tick_divider #(
    .PERIOD (UPD_PERIOD)
  ) u_slow_div (
    .clk   (clk),
    .reset (reset),
    .clear (transition),
    .tick  (slow_tick)
  );

  tick_divider #(
    .PERIOD (FAST_PERIOD)
  ) u_fast_div (
    .clk   (clk),
    .reset (reset),
    .clear (transition),
    .tick  (fast_tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StGameover: if (start_rise_q) state_d = StPlay;
      StPlay:             if (col_q) state_d = StCrash;
      StCrash: begin
        if (slow_tick && tick_cnt_q == TW'(CRASH_TICKS - 1)) begin
          state_d = (lives_q == 2'd0) ? StGameover : StGrace;
        end
      end
      StGrace: if (slow_tick && tick_cnt_q == TW'(GRACE_TICKS - 1)) state_d = StPlay;
      default: state_d = StIdle;
    endcase
  end

  assign transition = (state_d != state_q);
  assign running    = (state_q == StPlay) || (state_q == StGrace);
  assign blinking   = (state_q == StCrash) || (state_q == StGrace);
  assign starting   = (state_d == StPlay) && ((state_q == StIdle) || (state_q == StGameover));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      lives_q       <= 2'(LIVES);
      col_q         <= 1'b0;
      start_q       <= 1'b0;
      start_rise_q  <= 1'b0;
      tick_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      visible_q     <= 1'b1;
      upsig_q       <= 1'b0;
      upsig_fast_q  <= 1'b0;
      alive_q       <= 1'b0;
      game_over_q   <= 1'b0;
      score_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= colision;
      start_q       <= start;
      start_rise_q  <= start & ~start_q;
      upsig_q       <= slow_tick & running;
      upsig_fast_q  <= fast_tick & running;
      alive_q       <= running;
      game_over_q   <= (state_q == StGameover);
      score_clear_q <= starting;
      if (transition) begin
        tick_cnt_q  <= '0;
        blink_cnt_q <= '0;
        // Entering CRASH or GRACE starts the blink in the hidden phase.
        visible_q   <= !((state_d == StCrash) || (state_d == StGrace));
        if (starting) lives_q <= 2'(LIVES);
        if (state_d == StCrash && lives_q != 2'd0) lives_q <= lives_q - 2'd1;
      end else if (slow_tick && blinking) begin
        tick_cnt_q <= tick_cnt_q + TW'(1);
        if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
          blink_cnt_q <= '0;
          visible_q   <= ~visible_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end
    end
  end

  assign upsig          = upsig_q;
  assign upsig_fast     = upsig_fast_q;
  assign alive          = alive_q;
  assign player_visible = visible_q;
  assign score_clear    = score_clear_q;
  assign lives          = lives_q;
  assign game_over      = game_over_q;
  assign state          = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: time-in-state reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_game_sequencer;

  localparam int UPD   = 10;
  localparam int FAST  = 5;
  localparam int CRASH = 4;
  localparam int GRACE = 3;
  localparam int BLINK = 2;
  localparam int LIV   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       colision = 1'b0;
  logic       upsig, upsig_fast, alive, player_visible, score_clear, game_over;
  logic [1:0] lives;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  game_sequencer #(
    .UPD_PERIOD  (UPD),
    .FAST_PERIOD (FAST),
    .CRASH_TICKS (CRASH),
    .GRACE_TICKS (GRACE),
    .BLINK_TICKS (BLINK),
    .LIVES       (LIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .colision       (colision),
    .upsig          (upsig),
    .upsig_fast     (upsig_fast),
    .alive          (alive),
    .player_visible (player_visible),
    .score_clear    (score_clear),
    .lives          (lives),
    .game_over      (game_over),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // Reference model: state lifetimes derived from cycles spent in the state.
  int m_state, m_lives, m_age;
  bit m_valid = 0;
  bit m_col, m_start_q, m_rise, m_up, m_upf, m_alive, m_go, m_pv, m_sc;

  always @(posedge clk) begin : model
    int nxt;
    bit run, tick, ftick;
    if (reset) begin
      m_state = 0; m_lives = LIV; m_age = 0;
      m_col = 0; m_start_q = 0; m_rise = 0;
      m_up = 0; m_upf = 0; m_alive = 0; m_go = 0; m_pv = 1; m_sc = 0;
      m_valid = 1;
    end else begin
      run   = (m_state == 1) || (m_state == 3);
      tick  = (m_age % UPD) == UPD - 1;
      ftick = (m_age % FAST) == FAST - 1;
      nxt   = m_state;
      m_sc  = 0;
      case (m_state)
        0, 4: if (m_rise) begin nxt = 1; m_lives = LIV; m_sc = 1; end
        1: if (m_col) begin nxt = 2; if (m_lives > 0) m_lives--; end
        2: if (m_age == CRASH * UPD - 1) nxt = (m_lives == 0) ? 4 : 3;
        3: if (m_age == GRACE * UPD - 1) nxt = 1;
        default: ;
      endcase
      m_up    = tick && run;
      m_upf   = ftick && run;
      m_alive = run;
      m_go    = (m_state == 4);
      m_rise  = start && !m_start_q;
      m_start_q = start;
      m_col   = colision;
      m_age   = (nxt != m_state) ? 0 : m_age + 1;
      m_state = nxt;
      m_pv    = (m_state == 2 || m_state == 3) ? ((m_age / (BLINK * UPD)) % 2 == 1) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("state", int'(state), m_state);
      cmp("lives", int'(lives), m_lives);
      cmp("upsig", int'(upsig), int'(m_up));
      cmp("upsig_fast", int'(upsig_fast), int'(m_upf));
      cmp("alive", int'(alive), int'(m_alive));
      cmp("game_over", int'(game_over), int'(m_go));
      cmp("player_visible", int'(player_visible), int'(m_pv));
      cmp("score_clear", int'(score_clear), int'(m_sc));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    cmp("rst_state", int'(state), 0);
    cmp("rst_lives", int'(lives), 2);
    cmp("rst_alive", int'(alive), 0);
    cmp("rst_visible", int'(player_visible), 1);
    cmp("rst_game_over", int'(game_over), 0);
    step(3);

    // 1: start -> PLAY with a single score_clear, strobe cadence from entry.
    start = 1'b1;
    step(1);
    cmp("s1_still_idle", int'(state), 0);
    step(1);
    cmp("s1_play", int'(state), 1);
    cmp("s1_clear_on", int'(score_clear), 1);
    cmp("s1_lives", int'(lives), 2);
    step(1);
    cmp("s1_clear_off", int'(score_clear), 0);
    cmp("s1_alive", int'(alive), 1);
    step(4);
    cmp("s1_fast_5", int'(upsig_fast), 1);
    cmp("s1_no_up_5", int'(upsig), 0);
    step(4);
    cmp("s1_no_up_9", int'(upsig), 0);
    step(1);
    cmp("s1_up_10", int'(upsig), 1);
    step(1);
    cmp("s1_up_off", int'(upsig), 0);
    start = 1'b0;
    step(7);

    // 2: one-cycle collision -> CRASH for 40 cycles, blinking, then GRACE.
    colision = 1'b1;
    step(1);
    colision = 1'b0;
    cmp("s2_not_yet", int'(state), 1);
    step(1);
    cmp("s2_crash", int'(state), 2);
    cmp("s2_lives", int'(lives), 1);
    cmp("s2_hidden", int'(player_visible), 0);
    step(38);
    cmp("s2_blink_on", int'(player_visible), 1);
    step(1);
    cmp("s2_crash_end", int'(state), 2);
    step(1);
    cmp("s2_grace", int'(state), 3);
    cmp("s2_grace_hidden", int'(player_visible), 0);

    // 3: collision held through GRACE, then immediate re-crash and game over.
    colision = 1'b1;
    step(1);
    cmp("s3_lives_kept", int'(lives), 1);
    step(28);
    cmp("s3_grace_29", int'(state), 3);
    step(1);
    cmp("s3_play", int'(state), 1);
    step(1);
    cmp("s3_recrash", int'(state), 2);
    cmp("s3_lives0", int'(lives), 0);
    colision = 1'b0;
    start = 1'b1;
    step(40);
    cmp("s3_gameover", int'(state), 4);
    step(1);
    cmp("s3_go_flag", int'(game_over), 1);
    cmp("s3_not_alive", int'(alive), 0);

    // 4: start held since the crash must not restart; a fresh press does.
    step(5);
    cmp("s4_held", int'(state), 4);
    start = 1'b0;
    step(2);
    start = 1'b1;
    step(2);
    cmp("s4_restart", int'(state), 1);
    cmp("s4_clear", int'(score_clear), 1);
    cmp("s4_lives", int'(lives), 2);
    step(3);

    // 5: start edge and collision together in PLAY -> CRASH only.
    start = 1'b0;
    step(1);
    start = 1'b1;
    colision = 1'b1;
    step(1);
    start = 1'b0;
    colision = 1'b0;
    step(1);
    cmp("s5_crash", int'(state), 2);
    cmp("s5_no_clear", int'(score_clear), 0);
    cmp("s5_lives", int'(lives), 1);

    // 6: reset mid-CRASH.
    step(15);
    reset = 1'b1;
    step(1);
    cmp("s6_state", int'(state), 0);
    cmp("s6_lives", int'(lives), 2);
    cmp("s6_alive", int'(alive), 0);
    cmp("s6_visible", int'(player_visible), 1);
    cmp("s6_upsig", int'(upsig), 0);
    cmp("s6_fast", int'(upsig_fast), 0);
    reset = 1'b0;
    step(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller. Sequences the playfield datapath by generating the upsig/upsig_fast update strobes, the alive enable (music, scoreboard, background) and a player blink mask.
- Owns the attract / play / crash / respawn-grace / game-over state machine, the lives counter and the scoreboard clear pulse.
- Consumes the collision flag from the collision manager.

Parameters:
- UPD_PERIOD, 833333, clk cycles between upsig pulses (60 Hz at 50 MHz).
- FAST_PERIOD, 416667, clk cycles between upsig_fast pulses.
- CRASH_TICKS, 120, slow ticks spent in CRASH.
- GRACE_TICKS, 90, slow ticks spent in GRACE (collisions ignored).
- BLINK_TICKS, 8, slow ticks per blink half-period.
- LIVES, 3, lives loaded at game start (1..3).

Ports:
- clk  in  1  system pixel clock
- reset  in  1  synchronous, active-high
- start  in  1  start button, already debounced, level
- colision  in  1  combinational collision flag, level
- upsig  out  1  one-cycle game-update strobe
- upsig_fast  out  1  one-cycle background-scroll strobe
- alive  out  1  high while a game is running and not crashed
- player_visible  out  1  AND-mask for on_player_car
- score_clear  out  1  one-cycle scoreboard reset pulse
- lives  out  2  remaining lives
- game_over  out  1  high in GAMEOVER
- state  out  3  current FSM state, for debug

Behaviour:
- All logic on posedge clk. Reset is synchronous, active-high.
  - Reset values: state=IDLE; lives=LIVES; both divider counters=0; all strobes=0; alive=0; player_visible=1; game_over=0.
  - Reset mid-CRASH or mid-GRACE aborts the sequence immediately. No pending pulse survives.
- Dividers:
  - slow_cnt counts 0..UPD_PERIOD-1; slow_tick=1 when slow_cnt==UPD_PERIOD-1, then wraps to 0.
  - fast_cnt works the same way with FAST_PERIOD, giving fast_tick.
  - Both counters clear to 0 on every state transition. A new state's first slow_tick therefore comes exactly UPD_PERIOD cycles after entry.
- Outputs are registered, one cycle after the qualifying condition:
  - upsig = slow_tick AND state in {PLAY, GRACE}.
  - upsig_fast = fast_tick AND state in {PLAY, GRACE}.
  - alive = state in {PLAY, GRACE}.
  - game_over = state==GAMEOVER.
- colision is sampled through a single register (col_q) before use.
- start_rise is a rising-edge detect of start, registered.
- States (3-bit encoding, values fixed in package): IDLE=0, PLAY=1, CRASH=2, GRACE=3, GAMEOVER=4.
- IDLE: on start_rise -> PLAY. Load lives=LIVES and pulse score_clear for 1 cycle.
- PLAY: on col_q -> CRASH. Decrement lives (saturate at 0) and clear tick_cnt.
  - start is ignored. If col_q and start_rise coincide, CRASH is taken.
- CRASH:
  - tick_cnt increments on each slow_tick.
  - On the slow_tick where tick_cnt==CRASH_TICKS-1: lives==0 -> GAMEOVER, else -> GRACE.
  - upsig and upsig_fast are suppressed, which freezes the playfield. alive=0.
- GRACE:
  - col_q is ignored.
  - On the slow_tick where tick_cnt==GRACE_TICKS-1 -> PLAY.
- GAMEOVER: on start_rise -> PLAY, with lives reload and score_clear pulse.
  - A start held high through the crash does not retrigger; a fresh rising edge is required.
- player_visible:
  - Constant 1 in IDLE, PLAY and GAMEOVER.
  - In CRASH and GRACE it toggles every BLINK_TICKS slow ticks, starting at 0 on entry.
- tick_cnt width is clog2(max(CRASH_TICKS, GRACE_TICKS)).
- No collision can retrigger while in CRASH, GRACE or GAMEOVER.

Decomposition:
- Package game_seq_pkg holds:
  - the state encoding localparams (IDLE..GAMEOVER);
  - a clog2 function;
  - default timing constants.
- One sub-module, tick_divider (parameter PERIOD; ports clk, reset, clear, tick), instantiated twice for the slow and fast dividers.

Test Plan:
- All scenarios run with UPD_PERIOD=10, FAST_PERIOD=5, CRASH_TICKS=4, GRACE_TICKS=3, BLINK_TICKS=2, LIVES=2.
1. Reset, then start pulse -> score_clear high exactly 1 cycle; state=1; alive=1; lives=2; upsig pulses every 10 cycles; upsig_fast every 5 cycles; first upsig 10 cycles after the PLAY entry (ignoring output register).
2. PLAY, then colision high 1 cycle -> state=2 two cycles later; lives=1; no upsig for 40 cycles; player_visible toggles every 20 cycles; then state=3 (GRACE).
3. GRACE, colision held high throughout -> lives stays 1; after 30 cycles state=1; col_q still high -> immediate CRASH with lives=0; after CRASH state=4, game_over=1, alive=0.
4. GAMEOVER with start held high since before entry -> stays in state 4; release then press -> state=1, lives=2, score_clear pulse.
5. colision and start rising in the same cycle during PLAY -> CRASH entered, no score_clear.
6. reset asserted mid-CRASH -> next cycle state=0, lives=2, alive=0, player_visible=1, no strobes.
